// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every signal between the arbiter, its two requesters and the
// shared memory.
//   IF requester : if_req, if_addr -> ; <- if_rdata, if_done, if_stall
//   MA requester : ma_rd, ma_wr, ma_addr, ma_wdata -> ;
//                  <- ma_rdata, ma_done, ma_stall
//   control      : halt ->
//   memory       : <- mem_addr, mem_data_in, mem_enable, mem_wr,
//                     mem_createdump ; mem_data_out ->
// Modport slave is the arbiter's view. Modport master is the view of the
// surrounding system: the requesters plus the memory.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    logic        ma_rd;
    logic        ma_wr;
    logic [15:0] ma_addr;
    logic [15:0] ma_wdata;
    logic [15:0] ma_rdata;
    logic        ma_done;
    logic        ma_stall;

    logic        halt;

    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic        mem_createdump;
    logic [15:0] mem_data_out;

    modport slave (
        input  if_req, if_addr, ma_rd, ma_wr, ma_addr, ma_wdata, halt,
               mem_data_out,
        output if_rdata, if_done, if_stall, ma_rdata, ma_done, ma_stall,
               mem_addr, mem_data_in, mem_enable, mem_wr, mem_createdump
    );

    modport master (
        output if_req, if_addr, ma_rd, ma_wr, ma_addr, ma_wdata, halt,
               mem_data_out,
        input  if_rdata, if_done, if_stall, ma_rdata, ma_done, ma_stall,
               mem_addr, mem_data_in, mem_enable, mem_wr, mem_createdump
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch requester (IF) and the memory access requester (MA). A grant latches
// address, write data and write strobe into port registers. Those registers
// drive the memory unchanged for LAT cycles. A one-cycle done pulse then
// returns to the owner. A sticky halt defers the memory dump until the
// in-flight access has drained.
// Parameters:
//   LAT  memory access latency in cycles, legal range 1..15
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_arbiter_if.slave (requesters, halt and memory port)
module mem_arbiter #(
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY   = 3'd1,
        DONE   = 3'd2,
        DUMP   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_MA = 1'b1;

    state_t      state_q, state_d;
    logic        halt_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_owner_q, last_owner_d;
    logic        owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] ma_rdata_q, ma_rdata_d;

    logic        ma_any;
    logic        grant_ma;

    assign ma_any = bus.ma_rd | bus.ma_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            halt_q       <= 1'b0;
            cnt_q        <= 4'd0;
            last_owner_q <= OWNER_MA;
            owner_q      <= OWNER_IF;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            wr_q         <= 1'b0;
            if_rdata_q   <= 16'h0000;
            ma_rdata_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            // Sticky: once seen in any state, halt is remembered until reset.
            halt_q       <= halt_q | bus.halt;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            if_rdata_q   <= if_rdata_d;
            ma_rdata_q   <= ma_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        if_rdata_d   = if_rdata_q;
        ma_rdata_d   = ma_rdata_q;
        grant_ma     = 1'b0;

        case (state_q)
            IDLE: begin
                if (halt_q) begin
                    state_d = DUMP;
                end else if (bus.if_req || ma_any) begin
                    // On a tie, the requester not served last wins.
                    grant_ma = ma_any && (!bus.if_req || (last_owner_q == OWNER_IF));
                    owner_d  = grant_ma;
                    addr_d   = grant_ma ? bus.ma_addr : bus.if_addr;
                    wdata_d  = grant_ma ? bus.ma_wdata : 16'h0000;
                    // A write wins over a read when MA asserts both.
                    wr_d     = grant_ma & bus.ma_wr;
                    cnt_d    = 4'(LAT - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (owner_q == OWNER_MA) begin
                            ma_rdata_d = bus.mem_data_out;
                        end else begin
                            if_rdata_d = bus.mem_data_out;
                        end
                    end
                    last_owner_d = owner_q;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // No grant from DONE: the owner's request is still visible this
            // cycle and must not be served a second time.
            DONE:    state_d = IDLE;
            DUMP:    state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Port registers only reach the memory while an access is in flight.
    assign bus.mem_enable     = (state_q == BUSY);
    assign bus.mem_addr       = (state_q == BUSY) ? addr_q  : 16'h0000;
    assign bus.mem_data_in    = (state_q == BUSY) ? wdata_q : 16'h0000;
    assign bus.mem_wr         = (state_q == BUSY) & wr_q;
    assign bus.mem_createdump = (state_q == DUMP);

    assign bus.if_done  = (state_q == DONE) && (owner_q == OWNER_IF);
    assign bus.ma_done  = (state_q == DONE) && (owner_q == OWNER_MA);
    assign bus.if_rdata = if_rdata_q;
    assign bus.ma_rdata = ma_rdata_q;
    assign bus.if_stall = bus.if_req & ~bus.if_done;
    assign bus.ma_stall = ma_any & ~bus.ma_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. The main instance runs with LAT=4 against
// a small behavioural memory. A second instance runs with LAT=1 and a
// constant read value, to cover the shortest latency.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter_if u_if ();
    mem_arbiter_if u_if1 ();

    mem_arbiter #(.LAT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    mem_arbiter #(.LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.slave)
    );

    // Behavioural memory. Unwritten words read back their preload value.
    logic [15:0] mem_model   [0:255];
    logic        mem_written [0:255];

    function automatic logic [15:0] preload(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hA5A5;
            8'h20:   return 16'h5A5A;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_written[i] = 1'b0;
            mem_model[i]   = 16'h0000;
        end
        forever begin
            @(posedge clk);
            if (u_if.mem_enable && u_if.mem_wr) begin
                mem_model[u_if.mem_addr[7:0]]   = u_if.mem_data_in;
                mem_written[u_if.mem_addr[7:0]] = 1'b1;
            end
        end
    end

    assign u_if.mem_data_out = mem_written[u_if.mem_addr[7:0]] ?
                               mem_model[u_if.mem_addr[7:0]] :
                               preload(u_if.mem_addr[7:0]);
    assign u_if1.mem_data_out = 16'hC3C3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        u_if.if_req = 1'b0;  u_if.if_addr = '0;
        u_if.ma_rd = 1'b0;   u_if.ma_wr = 1'b0;
        u_if.ma_addr = '0;   u_if.ma_wdata = '0;  u_if.halt = 1'b0;
        u_if1.if_req = 1'b0; u_if1.if_addr = '0;
        u_if1.ma_rd = 1'b0;  u_if1.ma_wr = 1'b0;
        u_if1.ma_addr = '0;  u_if1.ma_wdata = '0; u_if1.halt = 1'b0;

        // Reset state
        tick();
        tick();
        u_if.ma_rd = 1'b1;
        #1;
        check("rst_ma_stall", 16'(u_if.ma_stall), 16'h1);
        check("rst_if_stall", 16'(u_if.if_stall), 16'h0);
        check("rst_mem_enable", 16'(u_if.mem_enable), 16'h0);
        check("rst_done", 16'({u_if.if_done, u_if.ma_done}), 16'h0);
        check("rst_if_rdata", u_if.if_rdata, 16'h0000);
        check("rst_ma_rdata", u_if.ma_rdata, 16'h0000);
        check("rst_dump", 16'(u_if.mem_createdump), 16'h0);
        u_if.ma_rd = 1'b0;
        rst = 1'b0;

        // IF read of 0x0010, request in IDLE cycle 0
        u_if.if_req = 1'b1; u_if.if_addr = 16'h0010;
        #1;
        check("if_c0_stall", 16'(u_if.if_stall), 16'h1);
        check("if_c0_enable", 16'(u_if.mem_enable), 16'h0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            check("if_busy_enable", 16'(u_if.mem_enable), 16'h1);
            check("if_busy_addr", u_if.mem_addr, 16'h0010);
            check("if_busy_wr", 16'(u_if.mem_wr), 16'h0);
            check("if_busy_stall", 16'(u_if.if_stall), 16'h1);
            check("if_busy_done", 16'(u_if.if_done), 16'h0);
            tick();
        end
        check("if_c5_done", 16'(u_if.if_done), 16'h1);
        check("if_c5_rdata", u_if.if_rdata, 16'hA5A5);
        check("if_c5_stall", 16'(u_if.if_stall), 16'h0);
        check("if_c5_enable", 16'(u_if.mem_enable), 16'h0);
        u_if.if_req = 1'b0;
        tick();
        check("if_c6_done", 16'(u_if.if_done), 16'h0);
        check("if_c6_rdata_held", u_if.if_rdata, 16'hA5A5);

        // MA write 0x1234 to 0x0040; inputs change mid-BUSY
        u_if.ma_wr = 1'b1; u_if.ma_addr = 16'h0040; u_if.ma_wdata = 16'h1234;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check("wr_busy_wr", 16'(u_if.mem_wr), 16'h1);
            check("wr_busy_addr", u_if.mem_addr, 16'h0040);
            check("wr_busy_data", u_if.mem_data_in, 16'h1234);
            if (c == 2) begin
                u_if.ma_addr = 16'h0099; u_if.ma_wdata = 16'hFFFF;
            end
            tick();
        end
        check("wr_done", 16'(u_if.ma_done), 16'h1);
        check("wr_rdata_unchanged", u_if.ma_rdata, 16'h0000);
        u_if.ma_wr = 1'b0; u_if.ma_rd = 1'b1; u_if.ma_addr = 16'h0040;
        tick();
        check("rd_idle_done", 16'(u_if.ma_done), 16'h0);
        repeat (4) tick();
        check("rd_c10_done", 16'(u_if.ma_done), 16'h0);
        tick();
        check("rd_done", 16'(u_if.ma_done), 16'h1);
        check("rd_rdata", u_if.ma_rdata, 16'h1234);
        u_if.ma_rd = 1'b0;
        tick();

        // Ties from reset: IF, then MA, then IF
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_if.if_req = 1'b1; u_if.if_addr = 16'h0010;
        u_if.ma_rd = 1'b1;  u_if.ma_addr = 16'h0040;
        tick();
        check("tie1_addr_if", u_if.mem_addr, 16'h0010);
        repeat (4) tick();
        check("tie1_if_done", 16'(u_if.if_done), 16'h1);
        check("tie1_ma_done", 16'(u_if.ma_done), 16'h0);
        check("tie1_ma_stall", 16'(u_if.ma_stall), 16'h1);
        u_if.if_addr = 16'h0020;
        tick();
        tick();
        check("tie2_addr_ma", u_if.mem_addr, 16'h0040);
        repeat (4) tick();
        check("tie2_ma_done", 16'(u_if.ma_done), 16'h1);
        check("tie2_ma_rdata", u_if.ma_rdata, 16'h1234);
        check("tie2_if_stall", 16'(u_if.if_stall), 16'h1);
        tick();
        tick();
        check("tie3_addr_if", u_if.mem_addr, 16'h0020);
        repeat (4) tick();
        check("tie3_if_done", 16'(u_if.if_done), 16'h1);
        check("tie3_if_rdata", u_if.if_rdata, 16'h5A5A);
        check("tie3_ma_stall", 16'(u_if.ma_stall), 16'h1);
        u_if.if_req = 1'b0; u_if.ma_rd = 1'b0;
        tick();

        // halt during an MA read of 0x0010
        u_if.ma_rd = 1'b1; u_if.ma_addr = 16'h0010;
        tick();
        tick();
        u_if.halt = 1'b1;
        tick();
        u_if.halt = 1'b0;
        tick();
        tick();
        check("halt_ma_done", 16'(u_if.ma_done), 16'h1);
        check("halt_ma_rdata", u_if.ma_rdata, 16'hA5A5);
        check("halt_no_dump_yet", 16'(u_if.mem_createdump), 16'h0);
        u_if.ma_rd = 1'b0;
        tick();
        check("halt_idle_dump", 16'(u_if.mem_createdump), 16'h0);
        u_if.if_req = 1'b1; u_if.if_addr = 16'h0010;
        tick();
        check("halt_dump", 16'(u_if.mem_createdump), 16'h1);
        check("halt_dump_enable", 16'(u_if.mem_enable), 16'h0);
        tick();
        check("halt_dump_once", 16'(u_if.mem_createdump), 16'h0);
        for (int c = 0; c < 4; c++) begin
            check("halted_enable", 16'(u_if.mem_enable), 16'h0);
            check("halted_if_stall", 16'(u_if.if_stall), 16'h1);
            tick();
        end

        // rst mid-BUSY abandons the access
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_if_rdata", u_if.if_rdata, 16'h0000);
        check("rst2_ma_rdata", u_if.ma_rdata, 16'h0000);
        tick();
        check("rst2_busy_enable", 16'(u_if.mem_enable), 16'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_abandon_enable", 16'(u_if.mem_enable), 16'h0);
        check("rst2_abandon_done", 16'(u_if.if_done), 16'h0);
        tick();
        check("rst2_regrant_enable", 16'(u_if.mem_enable), 16'h1);
        repeat (3) tick();
        check("rst2_early_done", 16'(u_if.if_done), 16'h0);
        tick();
        check("rst2_done", 16'(u_if.if_done), 16'h1);
        check("rst2_rdata", u_if.if_rdata, 16'hA5A5);
        check("rst2_dump", 16'(u_if.mem_createdump), 16'h0);
        u_if.if_req = 1'b0;
        tick();

        // LAT=1 instance: single BUSY cycle
        u_if1.if_req = 1'b1; u_if1.if_addr = 16'h0005;
        #1;
        check("lat1_c0_stall", 16'(u_if1.if_stall), 16'h1);
        tick();
        check("lat1_c1_enable", 16'(u_if1.mem_enable), 16'h1);
        check("lat1_c1_addr", u_if1.mem_addr, 16'h0005);
        tick();
        check("lat1_c2_enable", 16'(u_if1.mem_enable), 16'h0);
        check("lat1_c2_done", 16'(u_if1.if_done), 16'h1);
        check("lat1_c2_rdata", u_if1.if_rdata, 16'hC3C3);
        u_if1.if_req = 1'b0;
        tick();
        check("lat1_c3_done", 16'(u_if1.if_done), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF) and the memory-access requester (MA). It latches the winning request, holds the memory port stable for the full access latency, returns read data with a one-cycle done pulse, and stalls requesters that are waiting. It also defers the halt-time memory dump until in-flight traffic has drained. It sits between the IF/MA stages and the shared memory model.

## Interface
- LAT, 4: memory access latency in cycles; legal range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  IF read request; held with if_addr until if_done.
- if_addr  in  16  IF read address.
- if_rdata  out  16  IF read data; valid when if_done is high, held until the next IF completion.
- if_done  out  1  one-cycle IF completion pulse.
- if_stall  out  1  if_req & !if_done (combinational).
- ma_rd  in  1  MA read request.
- ma_wr  in  1  MA write request; takes precedence over ma_rd.
- ma_addr  in  16  MA address.
- ma_wdata  in  16  MA write data.
- ma_rdata  out  16  MA read data; valid when ma_done is high, held otherwise.
- ma_done  out  1  one-cycle MA completion pulse.
- ma_stall  out  1  (ma_rd|ma_wr) & !ma_done (combinational).
- halt  in  1  halt request; sticky once sampled.
- mem_addr  out  16  memory address.
- mem_data_in  out  16  memory write data.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_createdump  out  1  one-cycle dump strobe.
- mem_data_out  in  16  memory read data; valid in the last enabled cycle of an access.

## Operation
- States: IDLE, BUSY, DONE, DUMP, HALTED.
- IDLE:
  - If halt has been seen, go to DUMP.
  - Otherwise pick the owner:
    - Only one requester pending: that requester wins.
    - Both pending: the requester not granted last wins (round-robin via last_owner; reset value of last_owner = MA, so IF wins the first tie).
  - On grant: latch addr, wdata and wr (wr = ma_wr for MA, 0 for IF) into port registers; load cnt = LAT-1; go to BUSY.
- BUSY:
  - mem_enable=1 and mem_addr/mem_data_in/mem_wr come from the port registers, which are stable for all LAT cycles. Requester input changes during BUSY have no effect.
  - Writes repeat the same data every cycle, which is idempotent.
  - Decrement cnt each cycle. When cnt==0, capture mem_data_out into the owner's rdata (reads only), update last_owner, go to DONE.
- DONE: pulse the owner's done for one cycle; go to IDLE. No grant is made from DONE, so a requester's stale request is never re-granted.
- halt: sampled into a sticky flag in any state. An in-flight access completes normally; the DUMP state is then entered from IDLE.
- DUMP: mem_createdump=1 for exactly one cycle, mem_enable=0; go to HALTED.
- HALTED: terminal until rst. No grants; stalls follow the request inputs.
- ma_rd & ma_wr together: treated as a write; ma_rdata is unchanged.

## Timing
- Reset values: state IDLE, halt flag 0, cnt 0, last_owner MA; all outputs 0 (rdata registers 0; stalls reflect inputs combinationally).
- A request visible in IDLE at cycle T produces:
  - BUSY during T+1..T+LAT, with mem_enable high throughout.
  - Data capture at the end of T+LAT.
  - done high in T+LAT+1.
  - IDLE at T+LAT+2.
- Request-to-done latency is LAT+1 cycles; peak throughput is one access per LAT+2 cycles.
- LAT=1: BUSY lasts exactly one cycle.
- Simultaneous IF and MA in IDLE: exactly one grant; the loser stays stalled and is granted at the next IDLE.
- halt arriving during BUSY: dump occurs in the cycle after IDLE is reached, i.e. after the in-flight done pulse.
- rst during any state: next cycle is IDLE with all outputs at reset values. The access is abandoned with no done pulse and no dump.

## Test plan
- IF read only, LAT=4, if_addr=0x0010, memory holds 0xA5A5 there, request at cycle 0 -> mem_enable high cycles 1-4, if_done=1 and if_rdata=0xA5A5 in cycle 5, if_stall high cycles 0-4.
- MA write 0x1234 to 0x0040 followed by MA read of 0x0040 -> mem_wr high for 4 cycles with stable addr/data; the read returns ma_rdata=0x1234.
- IF and MA both requesting from reset -> IF granted first (last_owner=MA), MA granted next; further ties alternate.
- Change ma_addr mid-BUSY -> mem_addr unchanged until DONE.
- halt asserted during an MA read -> ma_done pulses first, then mem_createdump is high exactly one cycle and no further mem_enable occurs.
- rst asserted mid-BUSY -> next cycle mem_enable=0, no done pulse; a fresh request afterwards completes with LAT+1 latency.
